// File: rtl/seq_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes
// and small helpers that classify an operation.
package seq_mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_e;

  // Divide-class operations use the shift-subtract step.
  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIVU) || (op == MDU_REMU);
  endfunction

  // MULHU and REMU take their result from the upper half of the accumulator.
  function automatic logic op_takes_hi(input mdu_op_e op);
    return (op == MDU_MULHU) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/seq_mdu_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: {hi, lo} is {partial product, remaining multiplier}; operand is
// the multiplicand. Divide: {hi, lo} is {partial remainder, dividend/quotient};
// operand is the divisor. The quotient bit is shifted into lo[0].
module mdu_step
  import seq_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic           q_bit;

  // Shift-add multiply step or restoring divide step.
  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    q_bit   = 1'b0;
    hi_next = hi;
    lo_next = lo;
    if (op_is_div(op)) begin
      rem_sh  = {hi, lo[WIDTH-1]};
      q_bit   = (rem_sh >= {1'b0, operand});
      // Remainder stays below the divisor, so the subtraction fits in WIDTH bits.
      hi_next = rem_sh[WIDTH-1:0] - (q_bit ? operand : '0);
      lo_next = {lo[WIDTH-2:0], q_bit};
    end else begin
      sum     = lo[0] ? ({1'b0, hi} + {1'b0, operand}) : {1'b0, hi};
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_mdu.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one step per clock, with
// valid/ready handshakes on request and result sides.
module seq_mdu
  import seq_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state, state_next;
  mdu_op_e          op_q;
  mdu_op_e          op_in;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH-1:0] y_q;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  logic             last_step;

  assign op_in = mdu_op_e'(op);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (opnd_q),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          last_step  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture at accept, one iteration per RUN cycle, result load on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MDU_MUL;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      hi_q  <= '0;
      cnt_q <= CW'(WIDTH - 1);
      if (op_is_div(op_in)) begin
        lo_q   <= a;
        opnd_q <= b;
      end else begin
        lo_q   <= b;
        opnd_q <= a;
      end
    end else if (state == S_RUN) begin
      hi_q <= hi_step;
      lo_q <= lo_step;
      if (last_step) y_q <= op_takes_hi(op_q) ? hi_step : lo_step;
      else           cnt_q <= cnt_q - CW'(1);
    end
  end

  assign y    = y_q;
  assign zero = out_valid && (y_q == '0);

endmodule

// File: tb/tb_seq_mdu.sv
// Self-checking bench for seq_mdu at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_seq_mdu;
  import seq_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, or32 = 1'b1, ir32, ov32, z32;
  logic [1:0]  op32 = 2'b00;
  logic [31:0] a32 = '0, b32 = '0, y32;

  logic        iv8 = 1'b0, or8 = 1'b1, ir8, ov8, z8;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0, y8;

  seq_mdu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .y(y32), .zero(z32)
  );

  seq_mdu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .y(y8), .zero(z8)
  );

  typedef struct {
    logic [31:0] y;
    logic        z;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32, e8;
  int unsigned total = 0;
  int unsigned bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference result from plain integer arithmetic at width w.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input int w);
    logic [63:0] mask, p;
    mask = (64'd1 << w) - 64'd1;
    p    = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   p = p & mask;
      2'b01:   p = (p >> w) & mask;
      2'b10:   p = (b == 0) ? mask : {32'd0, a / b};
      default: p = (b == 0) ? {32'd0, a} : {32'd0, a % b};
    endcase
    return p[31:0];
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1:       r = 64'd1;
      2:       r = mask;
      default: r = {32'd0, $urandom} & mask;
    endcase
    return r[31:0];
  endfunction

  // Scoreboard consumers: a result is taken on each out_valid && out_ready cycle.
  always @(negedge clk) begin
    if (rst_n && ov32 && or32) begin
      if (sb32.size() == 0) begin
        total++; bad++;
        $display("FAIL w32_unexpected: got y=%h want no result at %0t", y32, $time);
      end else begin
        e32 = sb32.pop_front();
        chk("w32_y", y32, e32.y);
        chk("w32_zero", {31'd0, z32}, {31'd0, e32.z});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (sb8.size() == 0) begin
        total++; bad++;
        $display("FAIL w8_unexpected: got y=%h want no result at %0t", y8, $time);
      end else begin
        e8 = sb8.pop_front();
        chk("w8_y", {24'd0, y8}, e8.y);
        chk("w8_zero", {31'd0, z8}, {31'd0, e8.z});
      end
    end
  end

  task automatic push32(input logic [31:0] exp);
    exp_t e;
    e.y = exp;
    e.z = (exp == 0);
    sb32.push_back(e);
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int unsigned n = 0;
    while (!ir32 && n < 200) begin @(posedge clk); #1; n++; end
    if (!ir32) begin
      total++; bad++;
      $display("FAIL w32_accept_timeout: got in_ready=0 want 1 at %0t", $time);
      return;
    end
    op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
    push32(exp);
    @(posedge clk); #1;
    iv32 = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int unsigned n = 0;
    while (!ir8 && n < 200) begin @(posedge clk); #1; n++; end
    if (!ir8) begin
      total++; bad++;
      $display("FAIL w8_accept_timeout: got in_ready=0 want 1 at %0t", $time);
      return;
    end
    op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    e.y = model(op, {24'd0, a}, {24'd0, b}, 8);
    e.z = (e.y == 0);
    sb8.push_back(e);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic wait_valid32(output int unsigned n);
    n = 0;
    while (!ov32 && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb32.size() != 0 || sb8.size() != 0 || !ir32 || !ir8) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", sb32.size() + sb8.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[8];
    int unsigned n;

    tbl[0] = '{2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[3] = '{2'b10, 32'd100,      32'd7,        32'd14};
    tbl[4] = '{2'b11, 32'd100,      32'd7,        32'd2};
    tbl[5] = '{2'b11, 32'd21,       32'd7,        32'd0};
    tbl[6] = '{2'b10, 32'h12345678, 32'd0,        32'hFFFFFFFF};
    tbl[7] = '{2'b11, 32'h12345678, 32'd0,        32'h12345678};

    #1;
    chk("rst_in_ready", {31'd0, ir32}, 32'd1);
    chk("rst_out_valid", {31'd0, ov32}, 32'd0);
    chk("rst_y", y32, 32'd0);
    chk("rst_zero", {31'd0, z32}, 32'd0);
    chk("rst_w8_in_ready", {31'd0, ir8}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      issue32(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y);
      chk("busy_in_ready", {31'd0, ir32}, 32'd0);
      wait_valid32(n);
      chk("latency", n, 32'd32);
    end
    drain();

    // Stalled result with a request waiting; operands change but must be ignored.
    or32 = 1'b0;
    op32 = 2'b10; a32 = 32'd100; b32 = 32'd7; iv32 = 1'b1;
    push32(32'd14);
    @(posedge clk); #1;
    wait_valid32(n);
    chk("hold_latency", n, 32'd32);
    op32 = 2'b00; a32 = 32'd200; b32 = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'd0, ov32}, 32'd1);
      chk("hold_in_ready", {31'd0, ir32}, 32'd0);
      chk("hold_y", y32, 32'd14);
    end
    op32 = 2'b11; a32 = 32'd100; b32 = 32'd7;
    push32(32'd2);
    or32 = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, ir32}, 32'd1);
    chk("release_out_valid", {31'd0, ov32}, 32'd0);
    @(posedge clk); #1;
    chk("reaccept_in_ready", {31'd0, ir32}, 32'd0);
    iv32 = 1'b0;
    wait_valid32(n);
    chk("reaccept_latency", n, 32'd32);
    drain();

    // Reset midway through RUN discards the operation.
    issue32(2'b00, 32'h00001234, 32'h00005678, 32'h06260060);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    void'(sb32.pop_back());
    #1;
    chk("midrst_out_valid", {31'd0, ov32}, 32'd0);
    chk("midrst_y", y32, 32'd0);
    chk("midrst_in_ready", {31'd0, ir32}, 32'd1);
    chk("midrst_zero", {31'd0, z32}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue32(2'b01, 32'hDEADBEEF, 32'h12345678, 32'h0FD5BDEE);
    wait_valid32(n);
    chk("postrst_latency", n, 32'd32);
    drain();

    fork
      begin
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 2000; i++) begin
          op = 2'($urandom_range(0, 3));
          a  = pick(32);
          b  = pick(32);
          issue32(op, a, b, model(op, a, b, 32));
        end
      end
      begin
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 2000; i++) begin
          op = 2'($urandom_range(0, 3));
          a  = pick(8);
          b  = pick(8);
          issue8(op, a[7:0], b[7:0]);
        end
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
